// File: rtl/serial_full_subtractor.sv
// serial_full_subtractor
//   Bit-serial subtractor: diff = a - b - borrowin, one bit per clock, LSB first,
//   using one full-subtractor cell and a borrow flip-flop.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request, sampled only while idle
//   a, b, borrowin      operands, captured on the accepting edge
//   busy                high while an operation is in progress
//   done                one-cycle pulse when diff/borrowout/overflow update
//   diff                a - b - borrowin mod 2^WIDTH, held until next completion
//   borrowout           unsigned borrow out of the MSB
//   overflow            two's-complement signed overflow
module serial_full_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrowin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowout,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next_c;
  logic             bo_ff;
  logic [CW-1:0]    cnt;
  logic             last_c;
  logic             ai_c;
  logic             bi_c;
  logic             d_c;
  logic             bnext_c;

  // Full-subtractor cell on the current LSBs
  always_comb begin
    ai_c    = a_sr[0];
    bi_c    = b_sr[0];
    d_c     = ai_c ^ bi_c ^ bo_ff;
    bnext_c = (~ai_c & bi_c) | (~(ai_c ^ bi_c) & bo_ff);
  end

  // Result register with the new bit entering at the MSB (shift form also covers WIDTH=1)
  always_comb begin
    res_next_c = (res_sr >> 1) | (WIDTH'(d_c) << (WIDTH - 1));
    last_c     = (cnt == CW'(WIDTH - 1));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)  state_d = RUN;
      RUN:     if (last_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      bo_ff     <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
      borrowout <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            bo_ff <= borrowin;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next_c;
          bo_ff  <= bnext_c;
          cnt    <= cnt + CW'(1);
          if (last_c) begin
            diff      <= res_next_c;
            borrowout <= bnext_c;
            // signed overflow: borrow into MSB differs from borrow out of MSB
            overflow  <= bo_ff ^ bnext_c;
            done      <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_full_subtractor.sv
module tb_serial_full_subtractor;

  typedef struct {
    logic [63:0] diff;
    logic        bo;
    logic        ov;
    int          acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_fail;

  exp_t q8[$];
  exp_t q3[$];
  exp_t q1[$];

  logic       s8_start, s8_bin, s8_busy, s8_done, s8_bo, s8_ov;
  logic [7:0] s8_a, s8_b, s8_diff;
  logic       s3_start, s3_bin, s3_busy, s3_done, s3_bo, s3_ov;
  logic [2:0] s3_a, s3_b, s3_diff;
  logic       s1_start, s1_bin, s1_busy, s1_done, s1_bo, s1_ov;
  logic [0:0] s1_a, s1_b, s1_diff;

  serial_full_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .a(s8_a), .b(s8_b), .borrowin(s8_bin),
    .busy(s8_busy), .done(s8_done), .diff(s8_diff), .borrowout(s8_bo), .overflow(s8_ov));

  serial_full_subtractor #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(s3_start), .a(s3_a), .b(s3_b), .borrowin(s3_bin),
    .busy(s3_busy), .done(s3_done), .diff(s3_diff), .borrowout(s3_bo), .overflow(s3_ov));

  serial_full_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .a(s1_a), .b(s1_b), .borrowin(s1_bin),
    .busy(s1_busy), .done(s1_done), .diff(s1_diff), .borrowout(s1_bo), .overflow(s1_ov));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic exp_t model(int w, longint a, longint b, bit bin, int acc);
    exp_t   e;
    longint m, full, sa, sb, sf;
    m      = longint'(1) << w;
    full   = a - b - longint'(bin);
    e.diff = 64'(((full % m) + m) % m);
    e.bo   = (a < b + longint'(bin));
    sa     = (a >= m / 2) ? a - m : a;
    sb     = (b >= m / 2) ? b - m : b;
    sf     = sa - sb - longint'(bin);
    e.ov   = (sf < -(m / 2)) || (sf > m / 2 - 1);
    e.acc  = acc;
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name);
    n_chk  = n_chk + 1;
    n_fail = n_fail + 1;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  // Monitors: pop the expected result whenever a done pulse appears
  logic prev8;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) prev8 = 1'b0;
    else begin
      if (prev8) chk("done8_one_cycle", 64'(s8_done), 64'd0);
      if (s8_done) begin
        if (q8.size() == 0) fail_now("spurious_done8");
        else begin
          e = q8.pop_front();
          chk("diff8", 64'(s8_diff), e.diff);
          chk("borrowout8", 64'(s8_bo), 64'(e.bo));
          chk("overflow8", 64'(s8_ov), 64'(e.ov));
          chk("latency8", 64'(cyc - e.acc), 64'd8);
        end
      end
      prev8 = s8_done;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && s3_done) begin
      if (q3.size() == 0) fail_now("spurious_done3");
      else begin
        e = q3.pop_front();
        chk("diff3", 64'(s3_diff), e.diff);
        chk("borrowout3", 64'(s3_bo), 64'(e.bo));
        chk("overflow3", 64'(s3_ov), 64'(e.ov));
        chk("latency3", 64'(cyc - e.acc), 64'd3);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && s1_done) begin
      if (q1.size() == 0) fail_now("spurious_done1");
      else begin
        e = q1.pop_front();
        chk("diff1", 64'(s1_diff), e.diff);
        chk("borrowout1", 64'(s1_bo), 64'(e.bo));
        chk("overflow1", 64'(s1_ov), 64'(e.ov));
        chk("latency1", 64'(cyc - e.acc), 64'd1);
      end
    end
  end

  // Drivers: wait (bounded) for idle at a falling edge, then present one request
  task automatic op8(logic [7:0] a, logic [7:0] b, logic bin);
    int t = 0;
    @(negedge clk);
    while (s8_busy) begin
      @(negedge clk);
      t++;
      if (t > 100) begin fail_now("busy8_timeout"); return; end
    end
    s8_a = a; s8_b = b; s8_bin = bin; s8_start = 1'b1;
    @(posedge clk); #1;
    q8.push_back(model(8, longint'(a), longint'(b), bin, cyc));
    s8_start = 1'b0;
  endtask

  task automatic op3(logic [2:0] a, logic [2:0] b, logic bin);
    int t = 0;
    @(negedge clk);
    while (s3_busy) begin
      @(negedge clk);
      t++;
      if (t > 100) begin fail_now("busy3_timeout"); return; end
    end
    s3_a = a; s3_b = b; s3_bin = bin; s3_start = 1'b1;
    @(posedge clk); #1;
    q3.push_back(model(3, longint'(a), longint'(b), bin, cyc));
    s3_start = 1'b0;
  endtask

  task automatic op1(logic [0:0] a, logic [0:0] b, logic bin);
    int t = 0;
    @(negedge clk);
    while (s1_busy) begin
      @(negedge clk);
      t++;
      if (t > 100) begin fail_now("busy1_timeout"); return; end
    end
    s1_a = a; s1_b = b; s1_bin = bin; s1_start = 1'b1;
    @(posedge clk); #1;
    q1.push_back(model(1, longint'(a), longint'(b), bin, cyc));
    s1_start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q8.size() + q3.size() + q1.size()) != 0) begin
      @(negedge clk);
      t++;
      if (t > 300) begin fail_now("drain_timeout"); return; end
    end
    @(negedge clk);
  endtask

  initial begin
    cyc = 0; n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    s8_start = 0; s8_a = '0; s8_b = '0; s8_bin = 0;
    s3_start = 0; s3_a = '0; s3_b = '0; s3_bin = 0;
    s1_start = 0; s1_a = '0; s1_b = '0; s1_bin = 0;
    #3;
    chk("rst_busy", 64'(s8_busy), 64'd0);
    chk("rst_done", 64'(s8_done), 64'd0);
    chk("rst_diff", 64'(s8_diff), 64'd0);
    chk("rst_borrowout", 64'(s8_bo), 64'd0);
    chk("rst_overflow", 64'(s8_ov), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, issued back-to-back
    op8(8'h50, 8'h20, 1'b0);
    op8(8'h00, 8'h01, 1'b0);
    op8(8'h05, 8'h05, 1'b1);
    op8(8'h80, 8'h01, 1'b0);
    op8(8'h7F, 8'hFF, 1'b0);
    drain();

    // Start pulses mid-operation must be ignored
    op8(8'hC3, 8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    s8_a = 8'h11; s8_b = 8'hEE; s8_bin = 1'b0; s8_start = 1'b1;
    @(posedge clk); #1; s8_start = 1'b0;
    repeat (2) @(negedge clk);
    s8_a = 8'h99; s8_b = 8'h01; s8_bin = 1'b1; s8_start = 1'b1;
    @(posedge clk); #1; s8_start = 1'b0;
    drain();
    chk("ignored_start_idle", 64'(s8_busy), 64'd0);

    // Reset in the middle of an operation
    op8(8'hA5, 8'h17, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(s8_busy), 64'd0);
    chk("midrst_done", 64'(s8_done), 64'd0);
    chk("midrst_diff", 64'(s8_diff), 64'd0);
    chk("midrst_borrowout", 64'(s8_bo), 64'd0);
    chk("midrst_overflow", 64'(s8_ov), 64'd0);
    q8.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    op8(8'h3A, 8'h5B, 1'b1);
    op8(8'hFF, 8'h00, 1'b0);
    drain();

    // Random operands
    for (int i = 0; i < 150; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom));
    drain();

    // Exhaustive small widths
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 2; c++)
          op3(3'(a), 3'(b), 1'(c));
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 2; c++)
          op1(1'(a), 1'(b), 1'(c));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
